// File: rtl/mem_arbiter_if.sv
// Shared constants and the bundled requester/RAM signal set for the two-port memory arbiter.
// The arbiter binds to the slave view; the environment binds to the master view.
package Constants;
  localparam int WIDTH = 32;
endpackage

interface mem_arbiter_if #(parameter int WIDTH = Constants::WIDTH);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_valid;
  logic [WIDTH-1:0] if_rdata;
  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic [3:0]       dm_be;
  logic             dm_gnt;
  logic             dm_valid;
  logic [WIDTH-1:0] dm_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_rdata;
  logic             stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the fetch and data requesters.
// Each transfer takes WAIT_CYCLES access cycles plus one response cycle; grants open in IDLE/RESP.
module mem_arbiter #(
  parameter int WIDTH       = Constants::WIDTH,
  parameter int WAIT_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic P_IF = 1'b0;
  localparam logic P_DM = 1'b1;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic                   last_grant, owner;
  logic [WIDTH-1:0]       lat_addr, lat_wdata;
  logic [3:0]             lat_be;
  logic                   lat_we;
  logic [1:0][WIDTH-1:0]  rdata_q;
  logic                   accept, gnt_if, gnt_dm, any_gnt, last_acc;

  // Ties go to whichever port did not win last; reset holds both grants low.
  assign accept   = rst && (state != ACCESS);
  assign gnt_if   = accept & bus.if_req & (~bus.dm_req | (last_grant == P_DM));
  assign gnt_dm   = accept & bus.dm_req & (~bus.if_req | (last_grant == P_IF));
  assign any_gnt  = gnt_if | gnt_dm;
  assign last_acc = (cnt == 4'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_gnt  ? ACCESS : IDLE;
      ACCESS:  state_nxt = last_acc ? RESP   : ACCESS;
      RESP:    state_nxt = any_gnt  ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.if_gnt    = gnt_if;
    bus.dm_gnt    = gnt_dm;
    bus.mem_en    = (state == ACCESS);
    bus.mem_we    = (state == ACCESS) && (cnt == 4'd0) && lat_we;
    bus.if_valid  = (state == RESP) && (owner == P_IF);
    bus.dm_valid  = (state == RESP) && (owner == P_DM);
    bus.if_rdata  = rdata_q[P_IF];
    bus.dm_rdata  = rdata_q[P_DM];
    bus.mem_addr  = lat_addr;
    bus.mem_wdata = lat_wdata;
    bus.mem_be    = lat_be;
    bus.stall     = rst & ((state == ACCESS) | (bus.if_req & ~gnt_if) | (bus.dm_req & ~gnt_dm));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      last_grant <= P_IF;
      owner      <= P_IF;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_we     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (any_gnt) begin
        cnt        <= '0;
        last_grant <= gnt_dm;
        owner      <= gnt_dm;
        lat_addr   <= gnt_dm ? bus.dm_addr  : bus.if_addr;
        lat_wdata  <= gnt_dm ? bus.dm_wdata : '0;
        lat_be     <= gnt_dm ? bus.dm_be    : 4'hF;
        lat_we     <= gnt_dm & bus.dm_we;
      end else if ((state == ACCESS) && !last_acc) begin
        cnt <= cnt + 4'd1;
      end
      // Stores report zero so a stale load value never looks like store data.
      if ((state == ACCESS) && last_acc)
        rdata_q[owner] <= lat_we ? '0 : bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (1 and 3 access cycles) with a grant-driven
// scoreboard that pairs each valid pulse with the expectation queued at its grant.
module tb_mem_arbiter;
  logic clk, rst;
  int   n_tot = 0, n_pass = 0;

  typedef struct {logic port; logic [31:0] data;} exp_t;
  exp_t qa[$], qb[$];
  logic [31:0] exp_if_a, exp_dm_a, exp_if_b, exp_dm_b;

  mem_arbiter_if #(.WIDTH(32)) a ();
  mem_arbiter_if #(.WIDTH(32)) b ();

  mem_arbiter #(.WIDTH(32), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(a));
  mem_arbiter #(.WIDTH(32), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b));

  // RAM stand-in: read data is a fixed scramble of the address.
  assign a.mem_rdata = a.mem_addr ^ 32'h2402001A;
  assign b.mem_rdata = b.mem_addr ^ 32'h2402001A;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboards: push on grant, pop on valid; reset discards in-flight transfers.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) qa.delete();
    else begin
      if (a.if_gnt) begin e.port = 1'b0; e.data = exp_if_a; qa.push_back(e); end
      if (a.dm_gnt) begin e.port = 1'b1; e.data = exp_dm_a; qa.push_back(e); end
      if (a.if_valid || a.dm_valid) begin
        if (qa.size() == 0) chk("a_unexpected_valid", {30'd0, a.dm_valid, a.if_valid}, 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_valid_port", {31'd0, a.dm_valid}, {31'd0, e.port});
          chk("a_rdata", e.port ? a.dm_rdata : a.if_rdata, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) qb.delete();
    else begin
      if (b.if_gnt) begin e.port = 1'b0; e.data = exp_if_b; qb.push_back(e); end
      if (b.dm_gnt) begin e.port = 1'b1; e.data = exp_dm_b; qb.push_back(e); end
      if (b.if_valid || b.dm_valid) begin
        if (qb.size() == 0) chk("b_unexpected_valid", {30'd0, b.dm_valid, b.if_valid}, 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_valid_port", {31'd0, b.dm_valid}, {31'd0, e.port});
          chk("b_rdata", e.port ? b.dm_rdata : b.if_rdata, e.data);
        end
      end
    end
  end

  initial begin
    logic [4:0] tie_if, tie_dm, st_if, st_dm, st_stall;
    logic [3:0] w_en, w_we, w_vld;
    tie_if = 5'b00100; tie_dm = 5'b10001;           // bit i = cycle i
    st_if = 5'b00001; st_dm = 5'b00100; st_stall = 5'b01011;
    w_en = 4'b0111; w_we = 4'b0001; w_vld = 4'b1000; // bit i-1 = cycle i
    rst = 1'b0;
    {a.if_req, a.dm_req, a.dm_we, b.if_req, b.dm_req, b.dm_we} = '0;
    {a.if_addr, a.dm_addr, a.dm_wdata, b.if_addr, b.dm_addr, b.dm_wdata} = '0;
    a.dm_be = 4'h0; b.dm_be = 4'h0;
    {exp_if_a, exp_dm_a, exp_if_b, exp_dm_b} = '0;

    // Reset state, with requests held to show grants stay low.
    a.if_req = 1'b1; a.dm_req = 1'b1;
    step; @(negedge clk);
    chk("rst_if_gnt", {31'd0, a.if_gnt}, 32'd0);
    chk("rst_dm_gnt", {31'd0, a.dm_gnt}, 32'd0);
    chk("rst_stall", {31'd0, a.stall}, 32'd0);
    chk("rst_mem_en", {31'd0, a.mem_en}, 32'd0);
    chk("rst_mem_be", {28'd0, a.mem_be}, 32'd0);
    chk("rst_mem_addr", a.mem_addr, 32'd0);
    chk("rst_if_rdata", a.if_rdata, 32'd0);
    chk("rst_dm_valid", {31'd0, a.dm_valid}, 32'd0);
    step; a.if_req = 1'b0; a.dm_req = 1'b0; rst = 1'b1;

    // Single fetch, one access cycle.
    step; a.if_req = 1'b1; a.if_addr = 32'h10; exp_if_a = 32'h2402000A;
    @(negedge clk);
    chk("f1_if_gnt", {31'd0, a.if_gnt}, 32'd1);
    chk("f1_stall_gnt", {31'd0, a.stall}, 32'd0);
    step; a.if_req = 1'b0; @(negedge clk);
    chk("f1_mem_en", {31'd0, a.mem_en}, 32'd1);
    chk("f1_mem_we", {31'd0, a.mem_we}, 32'd0);
    chk("f1_mem_addr", a.mem_addr, 32'h10);
    chk("f1_mem_be", {28'd0, a.mem_be}, 32'hF);
    chk("f1_stall_acc", {31'd0, a.stall}, 32'd1);
    step; @(negedge clk);
    chk("f1_if_valid", {31'd0, a.if_valid}, 32'd1);
    chk("f1_mem_en_resp", {31'd0, a.mem_en}, 32'd0);
    chk("f1_stall_resp", {31'd0, a.stall}, 32'd0);

    // Both requesting continuously: dm, fetch, dm.
    step; step;
    a.if_req = 1'b1; a.if_addr = 32'h30; exp_if_a = 32'h2402002A;
    a.dm_req = 1'b1; a.dm_we = 1'b0; a.dm_addr = 32'h20; exp_dm_a = 32'h2402003A;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step;
      @(negedge clk);
      chk($sformatf("tie_if_gnt_c%0d", i), {31'd0, a.if_gnt}, {31'd0, tie_if[i]});
      chk($sformatf("tie_dm_gnt_c%0d", i), {31'd0, a.dm_gnt}, {31'd0, tie_dm[i]});
    end
    step; a.if_req = 1'b0; a.dm_req = 1'b0;
    step; step;

    // Store held pending behind a fetch: stall profile.
    a.if_req = 1'b1; a.if_addr = 32'h40; exp_if_a = 32'h2402005A;
    a.dm_req = 1'b1; a.dm_we = 1'b1; a.dm_addr = 32'h8; a.dm_wdata = 32'h12345678;
    a.dm_be = 4'hC; exp_dm_a = 32'h0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step;
      if (i == 1) a.if_req = 1'b0;
      if (i == 3) a.dm_req = 1'b0;
      @(negedge clk);
      chk($sformatf("st_if_gnt_c%0d", i), {31'd0, a.if_gnt}, {31'd0, st_if[i]});
      chk($sformatf("st_dm_gnt_c%0d", i), {31'd0, a.dm_gnt}, {31'd0, st_dm[i]});
      chk($sformatf("st_stall_c%0d", i), {31'd0, a.stall}, {31'd0, st_stall[i]});
      if (i == 3) begin
        chk("st_mem_we", {31'd0, a.mem_we}, 32'd1);
        chk("st_mem_be", {28'd0, a.mem_be}, 32'hC);
        chk("st_mem_wdata", a.mem_wdata, 32'h12345678);
      end
    end
    step;

    // Fetch pulse while dm owns the port is withdrawn.
    a.dm_req = 1'b1; a.dm_we = 1'b0; a.dm_addr = 32'h4; exp_dm_a = 32'h2402001E;
    @(negedge clk); chk("wd_dm_gnt", {31'd0, a.dm_gnt}, 32'd1);
    step; a.dm_req = 1'b0; a.if_req = 1'b1; a.if_addr = 32'h50;
    @(negedge clk);
    chk("wd_if_gnt_acc", {31'd0, a.if_gnt}, 32'd0);
    chk("wd_stall_acc", {31'd0, a.stall}, 32'd1);
    step; a.if_req = 1'b0; @(negedge clk);
    chk("wd_dm_valid", {31'd0, a.dm_valid}, 32'd1);
    chk("wd_if_gnt_resp", {31'd0, a.if_gnt}, 32'd0);
    step; step; @(negedge clk);
    chk("wd_no_if_valid", {31'd0, a.if_valid}, 32'd0);

    // Three-cycle RAM: load, then store reporting zero.
    step; b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 32'h10; exp_dm_b = 32'h2402000A;
    @(negedge clk); chk("w3_ld_gnt", {31'd0, b.dm_gnt}, 32'd1);
    step; b.dm_req = 1'b0;
    step; step; step; @(negedge clk);
    chk("w3_ld_valid", {31'd0, b.dm_valid}, 32'd1);
    step;
    b.dm_req = 1'b1; b.dm_we = 1'b1; b.dm_addr = 32'h8; b.dm_wdata = 32'hDEADBEEF;
    b.dm_be = 4'b0011; exp_dm_b = 32'h0;
    @(negedge clk); chk("w3_st_gnt", {31'd0, b.dm_gnt}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step;
      if (i == 1) b.dm_req = 1'b0;
      @(negedge clk);
      chk($sformatf("w3_mem_en_c%0d", i), {31'd0, b.mem_en}, {31'd0, w_en[i-1]});
      chk($sformatf("w3_mem_we_c%0d", i), {31'd0, b.mem_we}, {31'd0, w_we[i-1]});
      chk($sformatf("w3_dm_valid_c%0d", i), {31'd0, b.dm_valid}, {31'd0, w_vld[i-1]});
      if (i == 1) begin
        chk("w3_mem_addr", b.mem_addr, 32'h8);
        chk("w3_mem_wdata", b.mem_wdata, 32'hDEADBEEF);
        chk("w3_mem_be", {28'd0, b.mem_be}, 32'h3);
      end
    end

    // Reset in the second access cycle abandons the transfer.
    step; b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 32'h14; exp_dm_b = 32'h2402000E;
    @(negedge clk); chk("ab_gnt", {31'd0, b.dm_gnt}, 32'd1);
    step; b.dm_req = 1'b0;
    step; rst = 1'b0;
    step; @(negedge clk);
    chk("ab_mem_en", {31'd0, b.mem_en}, 32'd0);
    chk("ab_mem_we", {31'd0, b.mem_we}, 32'd0);
    chk("ab_dm_valid", {31'd0, b.dm_valid}, 32'd0);
    chk("ab_stall", {31'd0, b.stall}, 32'd0);
    chk("ab_mem_addr", b.mem_addr, 32'd0);
    chk("ab_mem_be", {28'd0, b.mem_be}, 32'd0);
    chk("ab_dm_rdata", b.dm_rdata, 32'd0);
    step; rst = 1'b1;
    repeat (4) step;
    b.if_req = 1'b1; b.if_addr = 32'h18; exp_if_b = 32'h24020002;
    b.dm_req = 1'b1; b.dm_addr = 32'h1C; exp_dm_b = 32'h24020006;
    @(negedge clk);
    chk("ab_tie_dm_gnt", {31'd0, b.dm_gnt}, 32'd1);
    chk("ab_tie_if_gnt", {31'd0, b.if_gnt}, 32'd0);
    step; b.if_req = 1'b0; b.dm_req = 1'b0;
    repeat (5) step;
    @(negedge clk);
    chk("a_sb_empty", qa.size(), 32'd0);
    chk("b_sb_empty", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
